// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder driving one full-adder cell, LSB first
`timescale 1ns/1ps

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // One-bit sum and carry of three inputs
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] S,
  output logic             CO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] s_reg;
  logic             co_reg;
  logic             done_reg;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_next;

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Sum bits enter at the top so bit i lands in position i after WIDTH shifts
  always_comb begin
    res_next = {fa_s, res_sr[WIDTH-1:1]};
  end

  // Sequencer: accept operands in IDLE, process one bit per clock in RUN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      s_reg    <= '0;
      co_reg   <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            a_sr   <= A;
            b_sr   <= B;
            carry  <= CI;
            res_sr <= '0;
            cnt    <= '0;
            state  <= ST_RUN;
          end
        end
        default: begin
          res_sr <= res_next;
          carry  <= fa_co;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            s_reg    <= res_next;
            co_reg   <= fa_co;
            done_reg <= 1'b1;
            state    <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Outputs are straight register/state views, so reset clears them at once
  always_comb begin
    BUSY = (state == ST_RUN);
    DONE = done_reg;
    S    = s_reg;
    CO   = co_reg;
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder
`timescale 1ns/1ps

module tb_serial_adder;

  localparam int W = 8;

  logic         CLK;
  logic         RST_N;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         CI;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] S;
  logic         CO;

  int total;
  int bad;

  serial_adder #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .A     (A),
    .B     (B),
    .CI    (CI),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .S     (S),
    .CO    (CO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: plain integer addition of the operands
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    int unsigned sum;
    sum = int'(a) + int'(b) + int'(ci);
    return sum[W:0];
  endfunction

  // Stimulus only: issue one add, return latency, busy cycles and result
  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        output int lat, output int busy_cycles,
                        output logic [W-1:0] s_out, output logic co_out);
    @(posedge CLK); #1;
    START = 1'b1; A = a; B = b; CI = ci;
    @(posedge CLK); #1;
    START = 1'b0; A = W'($urandom); B = W'($urandom); CI = 1'($urandom);
    lat = -1;
    busy_cycles = 0;
    for (int i = 1; i <= 30; i++) begin
      if (BUSY) busy_cycles++;
      @(posedge CLK); #1;
      if (DONE) begin
        lat = i;
        break;
      end
    end
    s_out = S;
    co_out = CO;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; START = 1'b0; A = '0; B = '0; CI = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if ({BUSY, DONE, S, CO} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%0b done=%0b s=%h co=%0b want all 0", BUSY, DONE, S, CO);
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bc;
    logic [W-1:0] s;
    logic co;
    logic [W:0] exp;
    exp = model(8'h5A, 8'h3C, 1'b0);
    do_add(8'h5A, 8'h3C, 1'b0, lat, bc, s, co);
    total++;
    if (lat !== W) begin bad++; $display("FAIL basic_latency got %0d want %0d", lat, W); end
    total++;
    if (bc !== W) begin bad++; $display("FAIL basic_busy_cycles got %0d want %0d", bc, W); end
    total++;
    if (BUSY !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got %0b want 0", BUSY); end
    total++;
    if ({co, s} !== exp || exp !== 9'h096) begin
      bad++; $display("FAIL basic_result got co=%0b s=%h want co=0 s=96", co, s);
    end
    @(posedge CLK); #1;
    total++;
    if (DONE !== 1'b0) begin bad++; $display("FAIL basic_done_width got %0b want 0", DONE); end
  endtask

  task automatic test_carry();
    int lat, bc;
    logic [W-1:0] s;
    logic co;
    do_add(8'hFF, 8'h01, 1'b0, lat, bc, s, co);
    total++;
    if ({co, s} !== model(8'hFF, 8'h01, 1'b0)) begin
      bad++; $display("FAIL carry_ff_01 got co=%0b s=%h want co=1 s=00", co, s);
    end
    do_add(8'hFF, 8'hFF, 1'b1, lat, bc, s, co);
    total++;
    if ({co, s} !== model(8'hFF, 8'hFF, 1'b1)) begin
      bad++; $display("FAIL carry_ff_ff_1 got co=%0b s=%h want co=1 s=ff", co, s);
    end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [W-1:0] s, ra, rb;
    logic co, rc;
    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      do_add(ra, rb, rc, lat, bc, s, co);
      total++;
      if ({co, s} !== model(ra, rb, rc) || lat !== W) begin
        bad++;
        $display("FAIL random_add %h+%h+%0b got co=%0b s=%h lat=%0d want %h lat=%0d",
                 ra, rb, rc, co, s, lat, model(ra, rb, rc), W);
      end
    end
  endtask

  task automatic test_busy_protect();
    int dones;
    @(posedge CLK); #1;
    START = 1'b1; A = 8'h10; B = 8'h20; CI = 1'b0;
    @(posedge CLK); #1;
    START = 1'b0;
    A = 8'hFF; B = 8'hFF; CI = 1'b1;
    dones = 0;
    for (int c = 1; c <= 24; c++) begin
      START = (c == 3 || c == 5);
      @(posedge CLK); #1;
      if (DONE) dones++;
      if (DONE) begin
        total++;
        if ({CO, S} !== model(8'h10, 8'h20, 1'b0)) begin
          bad++; $display("FAIL busy_protect_result got co=%0b s=%h want co=0 s=30", CO, S);
        end
      end
    end
    START = 1'b0;
    total++;
    if (dones !== 1) begin bad++; $display("FAIL busy_protect_done_count got %0d want 1", dones); end
  endtask

  task automatic test_back_to_back();
    int t, t1, t2, nd;
    t1 = -1; t2 = -1; nd = 0; t = 0;
    @(posedge CLK); #1;
    START = 1'b1; A = 8'h01; B = 8'h01; CI = 1'b0;
    @(posedge CLK); #1;
    A = 8'h80; B = 8'h80;
    for (int c = 1; c <= 40 && nd < 2; c++) begin
      @(posedge CLK); #1;
      t = c;
      if (t1 >= 0 && t == t1 + 1) START = 1'b0;
      if (DONE) begin
        nd++;
        if (nd == 1) begin
          t1 = t;
          total++;
          if ({CO, S} !== model(8'h01, 8'h01, 1'b0)) begin
            bad++; $display("FAIL b2b_first got co=%0b s=%h want co=0 s=02", CO, S);
          end
        end else begin
          t2 = t;
          total++;
          if ({CO, S} !== model(8'h80, 8'h80, 1'b0)) begin
            bad++; $display("FAIL b2b_second got co=%0b s=%h want co=1 s=00", CO, S);
          end
        end
      end
    end
    START = 1'b0;
    total++;
    if (nd !== 2 || (t2 - t1) !== W + 1) begin
      bad++; $display("FAIL b2b_interval got dones=%0d gap=%0d want dones=2 gap=%0d", nd, t2 - t1, W + 1);
    end
    repeat (W + 3) @(posedge CLK);
  endtask

  task automatic test_reset_mid();
    int lat, bc, dones;
    logic [W-1:0] s;
    logic co;
    @(posedge CLK); #1;
    START = 1'b1; A = 8'hAA; B = 8'h55; CI = 1'b0;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    total++;
    if ({BUSY, DONE, S, CO} !== '0) begin
      bad++; $display("FAIL reset_mid_clear got busy=%0b done=%0b s=%h co=%0b want all 0", BUSY, DONE, S, CO);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK); #1;
      if (DONE || BUSY) dones++;
    end
    total++;
    if (dones !== 0) begin bad++; $display("FAIL reset_mid_no_done got %0d active cycles want 0", dones); end
    do_add(8'h03, 8'h04, 1'b1, lat, bc, s, co);
    total++;
    if ({co, s} !== model(8'h03, 8'h04, 1'b1) || lat !== W) begin
      bad++; $display("FAIL reset_mid_new_add got co=%0b s=%h lat=%0d want s=08", co, s, lat);
    end
  endtask

  task automatic test_hold();
    int lat, bc, errs;
    logic [W-1:0] s;
    logic co;
    do_add(8'h5A, 8'h3C, 1'b0, lat, bc, s, co);
    errs = 0;
    for (int c = 0; c < 20; c++) begin
      A = W'($urandom); B = W'($urandom); CI = 1'($urandom);
      @(posedge CLK); #1;
      if ({CO, S} !== model(8'h5A, 8'h3C, 1'b0) || DONE !== 1'b0) errs++;
    end
    total++;
    if (errs !== 0) begin
      bad++; $display("FAIL hold_stable got %0d bad cycles (co=%0b s=%h done=%0b) want 0", errs, CO, S, DONE);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_basic();
    test_carry();
    test_random();
    test_busy_protect();
    test_back_to_back();
    test_reset_mid();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
